// File: rtl/dmem_pkg.sv
// Shared constants and the round-robin pick function for the data-memory arbiter.
package dmem_pkg;

  localparam int N_REQ          = 3;
  localparam int REQ_CORE0      = 0;
  localparam int REQ_CORE1      = 1;
  localparam int REQ_HOST       = 2;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;
  localparam int PTR_W          = $clog2(N_REQ);

  // Scan from ptr upward, wrapping, and return the first active request as one-hot.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [PTR_W-1:0] ptr);
    logic [N_REQ-1:0] g;
    logic             found;
    logic [PTR_W-1:0] idx;
    int               s;
    g     = '0;
    found = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      s = int'(ptr) + off;
      if (s >= N_REQ) s = s - N_REQ;
      idx = PTR_W'(s);
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Round-robin grant logic: combinational pick plus the rotating priority pointer.
module dmem_rr_arbiter
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt
);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;

  // Grant is forced off during reset so the BRAM never sees a stray enable.
  always_comb begin
    gnt = rst ? '0 : rr_pick(req, rr_ptr);
  end

  // Encode the one-hot grant to find the winner's index.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  // Priority moves to the requester just after the winner; it holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (|gnt) begin
      rr_ptr <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data BRAM between two cores and the host bridge.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            mem_en,
  output logic [DATA_WIDTH/8-1:0]         mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            clr_cnt,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    gnt_cnt
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]   rd_push;
  logic [NUM_REQ-1:0]   rd_tag_p [RD_LATENCY];
  logic [CNT_WIDTH-1:0] cnt_r    [NUM_REQ];

  dmem_rr_arbiter u_rr (
    .clk (ACLK),
    .rst (ARESET),
    .req (req),
    .gnt (gnt)
  );

  // Route the granted requester onto the BRAM port; byte writes only for stores.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mem_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        mem_we    = we[i] ? be[i*BE_W +: BE_W] : '0;
      end
    end
  end

  assign mem_en  = |gnt;
  assign rd_push = gnt & ~we;

  // Read tags ride alongside the BRAM latency; reset drops in-flight reads.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int s = 0; s < RD_LATENCY; s++) rd_tag_p[s] <= '0;
    end else begin
      // stage 0: tag captured with the BRAM access
      rd_tag_p[0] <= rd_push;
      // stages 1..: tag follows the BRAM output registers
      for (int s = 1; s < RD_LATENCY; s++) rd_tag_p[s] <= rd_tag_p[s-1];
    end
  end

  assign rvalid = rd_tag_p[RD_LATENCY-1];
  assign rdata  = mem_rdata;

  // Per-requester grant counters; a clear beats a simultaneous grant.
  always_ff @(posedge ACLK) begin
    if (ARESET || clr_cnt) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) cnt_r[i] <= cnt_r[i] + 1'b1;
      end
    end
  end

  // Flatten the counters onto the packed output bus.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) gnt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_r[i];
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (read latency 1 and 2) share stimulus
// and are checked against a request-level reference model.
module tb_dmem_arbiter;

  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, clr_cnt, init;
  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*BW-1:0] be;

  logic [N-1:0]    gnt1, gnt2, rv1, rv2;
  logic [DW-1:0]   rdata1, rdata2, mrd1, mrd2, mwd1, mwd2, r2a;
  logic            men1, men2;
  logic [BW-1:0]   mwe1, mwe2;
  logic [AW-1:0]   ma1, ma2;
  logic [N*CW-1:0] cnt1, cnt2;

  dmem_arbiter #(.RD_LATENCY(1)) dut1 (
    .ACLK(clk), .ARESET(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .gnt(gnt1), .rvalid(rv1), .rdata(rdata1), .mem_en(men1), .mem_we(mwe1),
    .mem_addr(ma1), .mem_wdata(mwd1), .mem_rdata(mrd1), .clr_cnt(clr_cnt), .gnt_cnt(cnt1)
  );

  dmem_arbiter #(.RD_LATENCY(2)) dut2 (
    .ACLK(clk), .ARESET(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .gnt(gnt2), .rvalid(rv2), .rdata(rdata2), .mem_en(men2), .mem_we(mwe2),
    .mem_addr(ma2), .mem_wdata(mwd2), .mem_rdata(mrd2), .clr_cnt(clr_cnt), .gnt_cnt(cnt2)
  );

  // BRAM models: word i preloaded with 0x100+i.
  logic [DW-1:0] bram1 [4096];
  logic [DW-1:0] bram2 [4096];
  always @(posedge clk) begin
    if (init) begin
      for (int a = 0; a < 4096; a++) begin
        bram1[a] <= DW'(32'h100 + a);
        bram2[a] <= DW'(32'h100 + a);
      end
    end else begin
      if (men1) begin
        for (int b = 0; b < BW; b++) if (mwe1[b]) bram1[ma1][b*8 +: 8] <= mwd1[b*8 +: 8];
        mrd1 <= bram1[ma1];
      end
      if (men2) begin
        for (int b = 0; b < BW; b++) if (mwe2[b]) bram2[ma2][b*8 +: 8] <= mwd2[b*8 +: 8];
        r2a <= bram2[ma2];
      end
      mrd2 <= r2a;
    end
  end

  // Reference model state
  int            ptr;
  logic [DW-1:0] rmem [4096];
  logic [CW-1:0] rcnt [N];
  logic [N-1:0]  htag [2];
  logic [DW-1:0] hdat [2];
  logic [N-1:0]  eg;
  int            mk;
  int            gnt_log [$];
  int            n_chk, n_pass;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [N-1:0] model_pick();
    logic [N-1:0] r;
    if (rst) return '0;
    for (int off = 0; off < N; off++) begin
      r = req >> ((ptr + off) % N);
      if (r[0]) return N'(1) << ((ptr + off) % N);
    end
    return '0;
  endfunction

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] b);
    req[i]             = 1'b1;
    we[i]              = w;
    addr[i*AW +: AW]   = a;
    wdata[i*DW +: DW]  = d;
    be[i*BW +: BW]     = b;
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge, retire granted requests.
  task automatic cycle();
    logic [AW-1:0] a;
    @(negedge clk);
    eg = model_pick();
    mk = -1;
    for (int i = 0; i < N; i++) if (eg[i]) mk = i;
    chk("gnt_l1", gnt1, eg);
    chk("gnt_l2", gnt2, eg);
    chk("mem_en", men1, |eg);
    chk("rvalid_l1", rv1, htag[0]);
    chk("rvalid_l2", rv2, htag[1]);
    if (htag[0] != 0) chk("rdata_l1", rdata1, hdat[0]);
    if (htag[1] != 0) chk("rdata_l2", rdata2, hdat[1]);
    for (int i = 0; i < N; i++) begin
      chk("cnt_l1", cnt1[i*CW +: CW], rcnt[i]);
      chk("cnt_l2", cnt2[i*CW +: CW], rcnt[i]);
    end
    if (mk >= 0) begin
      chk("mem_addr", ma1, addr[mk*AW +: AW]);
      chk("mem_we", mwe1, we[mk] ? be[mk*BW +: BW] : 4'h0);
      if (we[mk]) chk("mem_wdata", mwd1, wdata[mk*DW +: DW]);
    end else begin
      chk("mem_we_idle", mwe1, 4'h0);
    end
    @(posedge clk);
    if (rst) begin
      ptr = 0;
      for (int i = 0; i < N; i++) rcnt[i] = '0;
      htag[0] = '0;
      htag[1] = '0;
    end else begin
      htag[1] = htag[0];
      hdat[1] = hdat[0];
      htag[0] = '0;
      if (mk >= 0) begin
        gnt_log.push_back(mk);
        a = addr[mk*AW +: AW];
        if (!we[mk]) begin
          htag[0] = eg;
          hdat[0] = rmem[a];
        end else begin
          for (int b = 0; b < BW; b++)
            if (be[mk*BW + b]) rmem[a][b*8 +: 8] = wdata[mk*DW + b*8 +: 8];
        end
        ptr = (mk + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (clr_cnt) rcnt[i] = '0;
        else if (mk == i) rcnt[i] = rcnt[i] + 1;
      end
    end
    #1;
    if (mk >= 0) req[mk] = 1'b0;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [BW-1:0] b);
    set_req(i, 1'b1, a, d, b);
    for (int n = 0; n < 10 && req[i]; n++) cycle();
    if (req[i]) chk("wr_timeout", 0, 1);
  endtask

  task automatic rd(input int i, input logic [AW-1:0] a, output logic [DW-1:0] d);
    logic got;
    got = 1'b0;
    d   = 'x;
    set_req(i, 1'b0, a, '0, '0);
    for (int n = 0; n < 10 && !got; n++) begin
      cycle();
      if (rv1[i]) begin
        got = 1'b1;
        d   = rdata1;
      end
    end
    if (!got) chk("rd_timeout", 0, 1);
    cycle();
    cycle();
  endtask

  logic [DW-1:0] d;
  int t1a, t1b, t2a, t2b;
  logic [DW-1:0] d1a, d1b, d2a, d2b;

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; init = 1'b1; clr_cnt = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    ptr = 0;
    for (int a = 0; a < 4096; a++) rmem[a] = DW'(32'h100 + a);
    for (int i = 0; i < N; i++) rcnt[i] = '0;
    htag[0] = '0; htag[1] = '0;
    @(posedge clk);
    #1;
    init = 1'b0;

    // Grants stay off during reset even with everyone requesting.
    req = 3'b111;
    #1 chk("rst_gnt", gnt1, 3'b000);
    do_reset();
    chk("rst_cnt", cnt1, '0);
    chk("rst_rv", rv2, 3'b000);

    // Host write then read-back.
    wr(2, 12'h010, 32'hDEADBEEF, 4'hF);
    rd(2, 12'h010, d);
    chk("host_rd", d, 32'hDEADBEEF);

    // Round-robin fairness with all three reading.
    do_reset();
    gnt_log.delete();
    for (int j = 0; j < 9; j++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(j), '0, '0);
      cycle();
    end
    req = '0;
    for (int j = 0; j < 9; j++) chk("rr_order", gnt_log[j], j % 3);
    for (int i = 0; i < N; i++) chk("rr_cnt", cnt1[i*CW +: CW], 3);
    cycle(); cycle();

    // Pipelined reads core0 addr1 then core1 addr2.
    t1a = -1; t1b = -1; t2a = -1; t2b = -1;
    set_req(0, 1'b0, 12'd1, '0, '0);
    for (int n = 0; n < 6; n++) begin
      if (n == 1) set_req(1, 1'b0, 12'd2, '0, '0);
      cycle();
      if (rv1[0] && t1a < 0) begin t1a = n; d1a = rdata1; end
      if (rv1[1] && t1b < 0) begin t1b = n; d1b = rdata1; end
      if (rv2[0] && t2a < 0) begin t2a = n; d2a = rdata2; end
      if (rv2[1] && t2b < 0) begin t2b = n; d2b = rdata2; end
    end
    chk("pipe_l1_t0", t1a, 0);
    chk("pipe_l1_t1", t1b, 1);
    chk("pipe_l2_t0", t2a, 1);
    chk("pipe_l2_t1", t2b, 2);
    chk("pipe_l1_d0", d1a, 32'h101);
    chk("pipe_l1_d1", d1b, 32'h102);
    chk("pipe_l2_d0", d2a, 32'h101);
    chk("pipe_l2_d1", d2b, 32'h102);

    // Byte enables, including a write with no bytes enabled.
    wr(0, 12'd5, 32'h11223344, 4'hF);
    wr(0, 12'd5, 32'hAABBCCDD, 4'h5);
    rd(1, 12'd5, d);
    chk("be_merge", d, 32'h11BB33DD);
    wr(2, 12'd5, 32'h55555555, 4'h0);
    rd(0, 12'd5, d);
    chk("be_zero", d, 32'h11BB33DD);

    // Reset one cycle after a read grant.
    set_req(1, 1'b1, 12'd7, 32'h1, 4'hF);
    cycle();
    set_req(0, 1'b0, 12'd1, '0, '0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_mid_rv", rv2, 3'b000);
    set_req(1, 1'b0, 12'd3, '0, '0);
    set_req(2, 1'b0, 12'd4, '0, '0);
    #1 chk("rst_ptr", gnt1, 3'b010);
    for (int n = 0; n < 6; n++) cycle();

    // Clear collides with a grant to core0.
    set_req(0, 1'b0, 12'd3, '0, '0);
    clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    chk("clr_win", cnt1[0 +: CW], 0);
    set_req(0, 1'b0, 12'd3, '0, '0);
    cycle();
    chk("clr_after", cnt1[0 +: CW], 1);
    cycle(); cycle();

    // Random traffic on a small address window.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom), AW'($urandom_range(0, 15)), $urandom,
                  BW'($urandom_range(0, 15)));
      clr_cnt = ($urandom_range(0, 63) == 0);
      rst     = ($urandom_range(0, 255) == 0);
      cycle();
    end
    rst = 1'b0; clr_cnt = 1'b0;
    for (int n = 0; n < 10; n++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
